// File: rtl/reaction_display.sv
// Converts an 11-bit millisecond value to BCD (double dabble) and scans it onto a 4-digit 7-segment display.
// Optional leading-zero blanking: define REACTION_DISPLAY_BLANK_EN.
module reaction_display #(
  parameter int unsigned SCAN_DIV = 2
) (
  input  logic        clk1k,
  input  logic        reset,
  input  logic [10:0] value,
  input  logic        load,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t           state;
  logic [10:0]      bin;
  logic [15:0]      bcd;
  logic [3:0]       cnt;
  logic [15:0]      disp;
  logic [DIVW-1:0]  div;
  logic [1:0]       idx;
  logic [15:0]      adj;
  logic [3:0]       digit;
  logic             blank;

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk1k or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      disp  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin   <= value;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd10) state <= COMMIT;
        end
        COMMIT: begin
          disp  <= bcd;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion engine.
  always_ff @(posedge clk1k or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIVW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIVW'(1);
    end
  end

  always_comb begin
    digit = disp[{idx, 2'b00} +: 4];
    blank = 1'b0;
`ifdef REACTION_DISPLAY_BLANK_EN
    case (idx)
      2'd3:    blank = (disp[15:12] == 4'd0);
      2'd2:    blank = (disp[15:8] == 8'd0);
      2'd1:    blank = (disp[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    an = ~(4'b0001 << idx);
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (blank) seg = 7'b1111111;
  end

endmodule

// File: tb/tb_reaction_display.sv
// Directed self-checking bench for reaction_display (SCAN_DIV = 2).
module tb_reaction_display;

  logic        clk1k;
  logic        reset;
  logic [10:0] value;
  logic        load;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
`ifdef REACTION_DISPLAY_BLANK_EN
  localparam logic [6:0] SLZ = 7'b1111111;
`else
  localparam logic [6:0] SLZ = 7'b1000000;
`endif

  reaction_display #(.SCAN_DIV(2)) dut (
    .clk1k(clk1k),
    .reset(reset),
    .value(value),
    .load (load),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  initial clk1k = 1'b0;
  always #5 clk1k = ~clk1k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1k);
    #1;
  endtask

  // Wait (bounded) for the requested digit enable, then check its segments.
  task automatic show_digit(input string tag, input logic [3:0] an_want, input logic [6:0] seg_exp);
    for (int i = 0; i < 20 && an !== an_want; i++) tick();
    chk({tag, "_an"}, 32'(an), 32'(an_want));
    chk({tag, "_seg"}, 32'(seg), 32'(seg_exp));
  endtask

  // Strobe load and count the samples for which busy stays high.
  task automatic run_load(input logic [10:0] v, output int cyc);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      cyc++;
      tick();
    end
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'(S0));
    @(posedge clk1k);
    #1 reset = 1'b0;
    tick();
    chk("scan_hold_an", 32'(an), 32'b1110);
    tick();
    chk("scan_step_an", 32'(an), 32'b1101);
    chk("scan_lz_seg", 32'(seg), 32'(SLZ));

    run_load(11'd1234, cyc);
    chk("c1234_busy_cycles", 32'(cyc), 32'd12);
    show_digit("c1234_d0", 4'b1110, S4);
    show_digit("c1234_d1", 4'b1101, S3);
    show_digit("c1234_d2", 4'b1011, S2);
    show_digit("c1234_d3", 4'b0111, S1);

    run_load(11'd2047, cyc);
    chk("c2047_busy_cycles", 32'(cyc), 32'd12);
    show_digit("c2047_d3", 4'b0111, S2);
    show_digit("c2047_d2", 4'b1011, S0);
    show_digit("c2047_d1", 4'b1101, S4);
    show_digit("c2047_d0", 4'b1110, S7);

    // Second load five cycles into a conversion must be dropped.
    value = 11'd500;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    cyc   = 0;
    for (int i = 1; i < 30 && busy; i++) begin
      cyc++;
      if (i == 5) begin
        value = 11'd9;
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    chk("lwb_busy_cycles", 32'(cyc), 32'd12);
    tick();
    tick();
    chk("lwb_not_queued", 32'(busy), 32'd0);
    show_digit("lwb_d3", 4'b0111, SLZ);
    show_digit("lwb_d2", 4'b1011, S5);
    show_digit("lwb_d1", 4'b1101, S0);
    show_digit("lwb_d0", 4'b1110, S0);

    // Reset six cycles after load aborts the conversion and clears the display.
    value = 11'd1234;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rmc_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    chk("rmc_busy", 32'(busy), 32'd0);
    chk("rmc_an", 32'(an), 32'b1110);
    chk("rmc_seg", 32'(seg), 32'(S0));
    reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("rmc_no_commit_busy", 32'(busy), 32'd0);
    show_digit("rmc_d2", 4'b1011, SLZ);
    show_digit("rmc_d3", 4'b0111, SLZ);
    show_digit("rmc_d1", 4'b1101, SLZ);
    show_digit("rmc_d0", 4'b1110, S0);

    run_load(11'd7, cyc);
    chk("c7_busy_cycles", 32'(cyc), 32'd12);
    show_digit("c7_d3", 4'b0111, SLZ);
    show_digit("c7_d2", 4'b1011, SLZ);
    show_digit("c7_d1", 4'b1101, SLZ);
    show_digit("c7_d0", 4'b1110, S7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
